radix4_mul_ctrl: RTL
====================

RADIX4_MUL_CTRL -- requirements
Module: radix4_mul_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width; even, >= 4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request to multiply; sampled only when state is IDLE or DONE.
REQ-005 a  in  WIDTH  multiplicand, sampled at the edge that accepts start.
REQ-006 b  in  WIDTH  multiplier, sampled at the edge that accepts start.
REQ-007 busy  out  1  high while state is RUN.
REQ-008 done  out  1  single-cycle pulse, high while state is DONE.
REQ-009 product  out  2*WIDTH  result; valid from done onward, held until the next accepted start.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE; next-state is a pure function of state, start and iteration counter.
REQ-011 IDLE: start=1 loads operands, clears accumulator and counter, sets the Booth guard bit q_m1=0, then goes to RUN; start=0 stays in IDLE.
REQ-012 RUN: each cycle performs one radix-4 Booth step, then increments the counter; after iteration N-1 the FSM goes to DONE.
REQ-013 N SHALL be WIDTH/2 in signed mode.
REQ-014 Booth step: the triplet {q[1],q[0],q_m1} selects a partial product: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M.
REQ-015 Partial-product add/sub SHALL use an accumulator WIDTH+2 bits wide (two's complement), with M sign-extended.
REQ-016 The shift SHALL be an arithmetic right shift by 2 of {acc,q,q_m1}: acc takes two copies of its sign bit; q takes acc[1:0] at its top; q_m1 takes the old q[1].
REQ-017 DONE: product = {acc[WIDTH-1:0], q} and done=1 for exactly this one cycle.
REQ-018 DONE with start=1 SHALL accept the new operation (back-to-back); start=0 returns to IDLE.
REQ-019 start while in RUN SHALL be ignored; operands are not resampled and latency is unchanged.
REQ-020 Latency: done SHALL be high in the cycle following the Nth rising edge after the edge that accepted start (signed WIDTH=8: 4 edges).
REQ-021 product SHALL update only on entry to DONE; a, b and start changes never alter it otherwise.

Reset
REQ-022 rst=1 at a rising edge forces IDLE, busy=0, done=0, product=0, acc=0, q=0, q_m1=0, counter=0.
REQ-023 rst in RUN SHALL abort the operation with no done pulse; rst has priority over start.

Configuration
REQ-024 Macro RADIX4_MUL_UNSIGNED_EN defined: operands are unsigned and zero-extended; the accumulator is WIDTH+3 bits; the multiplier register is WIDTH+2 bits; N = WIDTH/2+1; product is the low 2*WIDTH bits of {acc,q}.
REQ-025 Macro not defined: operands are two's-complement signed and REQ-013..REQ-017 apply as written.

Structure
REQ-026 Shared package radix4_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the Booth select encoding constants (PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2).
REQ-027 Sub-module radix4_pp_sel, combinational: triplet plus M in, sign-extended partial product out.
REQ-028 The shift-by-2 SHALL be inline logic in radix4_mul_ctrl.

Verification (WIDTH=8)
REQ-029 Signed: a=3, b=5, start pulse -> done exactly 4 edges later, product=0x000F, busy high for 4 cycles.
REQ-030 Signed corners: -128 x -128 -> 0x4000; 127 x -128 -> 0xC080; -1 x 1 -> 0xFFFF.
REQ-031 start held high through RUN with a/b changing -> single result for the operands sampled at acceptance; then back-to-back 2 x 3 accepted in the DONE cycle -> second done 4 edges later with 0x0006.
REQ-032 rst asserted in the 2nd RUN cycle -> next cycle IDLE, product=0, no done pulse; a new start then completes normally.
REQ-033 RADIX4_MUL_UNSIGNED_EN: 255 x 255 -> 0xFE01 after 5 edges; 200 x 3 -> 0x0258.
REQ-034 Random signed and unsigned sweep (>= 10k operand pairs) compared against a reference multiply; done pulse width is always 1.

Source files
------------

// File: rtl/radix4_pkg.sv
// Shared FSM state codes and Booth partial-product select encoding for the radix-4 multiplier.
package radix4_pkg;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   typedef logic [2:0] pp_sel_t;
   localparam pp_sel_t PP_ZERO = 3'd0;
   localparam pp_sel_t PP_POS1 = 3'd1;
   localparam pp_sel_t PP_POS2 = 3'd2;
   localparam pp_sel_t PP_NEG1 = 3'd3;
   localparam pp_sel_t PP_NEG2 = 3'd4;

   // Triplet is {q[1], q[0], q_m1}.
   function automatic pp_sel_t booth_sel(input logic [2:0] triplet);
      pp_sel_t sel;
      case (triplet)
         3'b001, 3'b010: sel = PP_POS1;
         3'b011:         sel = PP_POS2;
         3'b100:         sel = PP_NEG2;
         3'b101, 3'b110: sel = PP_NEG1;
         default:        sel = PP_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/radix4_mul_ctrl_if.sv
// Request/result bundle between a multiply requester and radix4_mul_ctrl.
interface radix4_mul_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/radix4_pp_sel.sv
// Combinational Booth partial-product select: extends M to accumulator width and applies 0/+-M/+-2M.
module radix4_pp_sel
   import radix4_pkg::*;
#(
   parameter int MW       = 8,
   parameter int AW       = 10,
   parameter bit M_SIGNED = 1'b1
) (
   input  logic [2:0]    triplet_i,
   input  logic [MW-1:0] m_i,
   output logic [AW-1:0] pp_o
);

   logic [AW-1:0] m_ext;
   logic [AW-1:0] m_x2;
   logic          ext_bit;

   assign ext_bit = M_SIGNED ? m_i[MW-1] : 1'b0;
   assign m_ext   = {{(AW-MW){ext_bit}}, m_i};
   assign m_x2    = {m_ext[AW-2:0], 1'b0};

   always_comb begin
      pp_o = '0;
      case (booth_sel(triplet_i))
         PP_POS1: pp_o = m_ext;
         PP_POS2: pp_o = m_x2;
         PP_NEG1: pp_o = '0 - m_ext;
         PP_NEG2: pp_o = '0 - m_x2;
         default: pp_o = '0;
      endcase
   end

endmodule

// File: rtl/radix4_mul_ctrl.sv
// Iterative radix-4 Booth multiplier, two bits of multiplier per cycle.
// RADIX4_MUL_UNSIGNED_EN selects unsigned operands (one extra iteration); default is signed.
module radix4_mul_ctrl
   import radix4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   radix4_mul_ctrl_if.slave  bus
);

`ifdef RADIX4_MUL_UNSIGNED_EN
   localparam int AW       = WIDTH + 3;
   localparam int QW       = WIDTH + 2;
   localparam int NIT      = WIDTH/2 + 1;
   localparam bit M_SIGNED = 1'b0;
`else
   localparam int AW       = WIDTH + 2;
   localparam int QW       = WIDTH;
   localparam int NIT      = WIDTH/2;
   localparam bit M_SIGNED = 1'b1;
`endif
   localparam int CW = $clog2(NIT + 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [QW-1:0]       q_q, q_d;
   logic                qm1_q, qm1_d;
   logic [WIDTH-1:0]    m_q, m_d;
   logic [2*WIDTH-1:0]  prod_q, prod_d;
   logic [AW-1:0]       pp;
   logic [AW-1:0]       sum;

   radix4_pp_sel #(
      .MW       (WIDTH),
      .AW       (AW),
      .M_SIGNED (M_SIGNED)
   ) u_pp_sel (
      .triplet_i ({q_q[1:0], qm1_q}),
      .m_i       (m_q),
      .pp_o      (pp)
   );

   assign sum = acc_q + pp;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      prod_d  = prod_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               m_d     = bus.a;
               q_d     = QW'(bus.b);
               acc_d   = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Arithmetic shift right by 2 of {sum, q, q_m1}.
            acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
            q_d   = {sum[1:0], q_q[QW-1:2]};
            qm1_d = q_q[1];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NIT - 1)) begin
               state_d = DONE;
`ifdef RADIX4_MUL_UNSIGNED_EN
               prod_d  = {acc_d[WIDTH-3:0], q_d};
`else
               prod_d  = {acc_d[WIDTH-1:0], q_d};
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         prod_q  <= prod_d;
      end
   end

   assign bus.busy    = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.product = prod_q;

endmodule
